// File: rtl/bcd_conv_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// bcd_conv_arbiter_pkg : shared state encoding and BCD constants
// Rev 1.0
// ============================================================================
package bcd_conv_arbiter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_LAUNCH = ST_LAUNCH,
    S_WAIT   = ST_WAIT,
    S_RESP   = ST_RESP
  } state_e;

  localparam int BCD_MAX = 999;
  localparam int BCD_W   = 12;

endpackage
`default_nettype wire

// File: rtl/bcd_conv_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// bcd_conv_arbiter_rr_pick : combinational round-robin pick, first at ptr+1
// Rev 1.0
// ============================================================================
module bcd_conv_arbiter_rr_pick #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt,
  output logic             any
);

  logic [N_REQ-1:0] eligible;
  logic [IDX_W-1:0] idx;

  always_comb begin
    eligible = req & ~mask;
    gnt      = '0;
    any      = 1'b0;
    idx      = '0;
    // Walk from ptr+1 around the ring; the first eligible hit wins.
    for (int i = 1; i <= N_REQ; i++) begin
      idx = IDX_W'((int'(ptr) + i) % N_REQ);
      if (!any && eligible[idx]) begin
        any = 1'b1;
        gnt = idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_conv_arbiter.sv
`default_nettype none
// ============================================================================
// bcd_conv_arbiter : shares one binary-to-BCD converter among N_REQ clients
// Rev 1.0
// ============================================================================
module bcd_conv_arbiter
  import bcd_conv_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int BIN_W   = 10,
  parameter int TIMEOUT = 31
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*BIN_W-1:0] bin_in,
  output logic [N_REQ-1:0]       ack,
  output logic [BCD_W-1:0]       resp_bcd,
  output logic                   resp_err,
  output logic                   busy,
  output logic                   conv_start,
  output logic [BIN_W-1:0]       conv_bin,
  input  logic                   conv_ready,
  input  logic                   conv_done_tick,
  input  logic [3:0]             conv_bcd2,
  input  logic [3:0]             conv_bcd1,
  input  logic [3:0]             conv_bcd0
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  gnt_q, gnt_d;
  logic [BIN_W-1:0]  conv_bin_q, conv_bin_d;
  logic [BCD_W-1:0]  resp_bcd_q, resp_bcd_d;
  logic              resp_err_q, resp_err_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              first_idle_q, first_idle_d;

  logic [N_REQ-1:0]  pick_mask;
  logic [IDX_W-1:0]  pick_gnt;
  logic              pick_any;
  logic [BIN_W-1:0]  pick_bin;

  // Hide the just-served requester for one cycle so a late req drop is not re-served.
  assign pick_mask = first_idle_q ? (N_REQ'(1) << gnt_q) : '0;
  assign pick_bin  = bin_in[int'(pick_gnt)*BIN_W +: BIN_W];

  bcd_conv_arbiter_rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req  (req),
    .mask (pick_mask),
    .ptr  (ptr_q),
    .gnt  (pick_gnt),
    .any  (pick_any)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_d        = gnt_q;
    conv_bin_d   = conv_bin_q;
    resp_bcd_d   = resp_bcd_q;
    resp_err_d   = resp_err_q;
    wd_d         = wd_q;
    first_idle_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_any && conv_ready) begin
          gnt_d      = pick_gnt;
          conv_bin_d = pick_bin;
          if (pick_bin > BIN_W'(BCD_MAX)) begin
            resp_err_d = 1'b1;
            resp_bcd_d = '0;
            state_d    = S_RESP;
          end else begin
            state_d    = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done tick in the timeout cycle still delivers the real result.
        if (conv_done_tick) begin
          resp_bcd_d = {conv_bcd2, conv_bcd1, conv_bcd0};
          resp_err_d = 1'b0;
          state_d    = S_RESP;
        end else if (wd_q == WD_W'(TIMEOUT)) begin
          resp_bcd_d = '0;
          resp_err_d = 1'b1;
          state_d    = S_RESP;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_RESP: begin
        ptr_d        = gnt_q;
        first_idle_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= IDX_W'(N_REQ - 1);
      gnt_q        <= '0;
      conv_bin_q   <= '0;
      resp_bcd_q   <= '0;
      resp_err_q   <= 1'b0;
      wd_q         <= '0;
      first_idle_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_q        <= gnt_d;
      conv_bin_q   <= conv_bin_d;
      resp_bcd_q   <= resp_bcd_d;
      resp_err_q   <= resp_err_d;
      wd_q         <= wd_d;
      first_idle_q <= first_idle_d;
    end
  end

  assign ack        = (state_q == S_RESP) ? (N_REQ'(1) << gnt_q) : '0;
  assign busy       = (state_q != S_IDLE);
  assign conv_start = (state_q == S_LAUNCH);
  assign conv_bin   = conv_bin_q;
  assign resp_bcd   = resp_bcd_q;
  assign resp_err   = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_conv_arbiter.sv
`default_nettype none
// ============================================================================
// tb_bcd_conv_arbiter : directed + random checks against a transaction model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_bcd_conv_arbiter;

  localparam int N  = 4;
  localparam int BW = 10;
  localparam int TO = 31;

  logic            clk;
  logic            reset_n;
  logic [N-1:0]    req;
  logic [N*BW-1:0] bin_in;
  logic [N-1:0]    ack;
  logic [11:0]     resp_bcd;
  logic            resp_err;
  logic            busy;
  logic            conv_start;
  logic [BW-1:0]   conv_bin;
  logic            conv_ready;
  logic            conv_done_tick;
  logic [3:0]      conv_bcd2, conv_bcd1, conv_bcd0;

  int vectors;
  int fails;
  int mptr;
  bit hang;

  bcd_conv_arbiter #(.N_REQ(N), .BIN_W(BW), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req            (req),
    .bin_in         (bin_in),
    .ack            (ack),
    .resp_bcd       (resp_bcd),
    .resp_err       (resp_err),
    .busy           (busy),
    .conv_start     (conv_start),
    .conv_bin       (conv_bin),
    .conv_ready     (conv_ready),
    .conv_done_tick (conv_done_tick),
    .conv_bcd2      (conv_bcd2),
    .conv_bcd1      (conv_bcd1),
    .conv_bcd0      (conv_bcd0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Converter model: 10 shift cycles after start, done tick on the 11th edge.
  int          ccnt;
  logic [9:0]  copnd;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ccnt           <= 0;
      copnd          <= '0;
      conv_ready     <= 1'b1;
      conv_done_tick <= 1'b0;
      conv_bcd2      <= '0;
      conv_bcd1      <= '0;
      conv_bcd0      <= '0;
    end else begin
      conv_done_tick <= 1'b0;
      if (ccnt > 0) begin
        ccnt <= ccnt - 1;
        if (ccnt == 1) begin
          conv_done_tick <= 1'b1;
          conv_ready     <= 1'b1;
          conv_bcd2      <= 4'(copnd / 100);
          conv_bcd1      <= 4'((copnd / 10) % 10);
          conv_bcd0      <= 4'(copnd % 10);
        end
      end else if (conv_start && !hang) begin
        ccnt       <= 10;
        copnd      <= conv_bin;
        conv_ready <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int to_bcd(input int v);
    return (v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  // Wait up to `limit` cycles for an ack; returns cycles waited and start pulses seen.
  task automatic wait_ack(input int limit, output int k, output int starts);
    k = 0;
    starts = 0;
    while (k < limit) begin
      @(negedge clk);
      k++;
      if (conv_start) starts++;
      if (ack != '0) break;
    end
  endtask

  // Model: serve all requesters in `set` round-robin from mptr; each drops req on its ack.
  task automatic run_batch(input logic [N-1:0] set, input int ops[N]);
    logic [N-1:0] pending;
    bit first;
    int w, c, lat, k, starts, exp_bcd, exp_st;
    bit exp_err;
    pending = set;
    first = 1;
    for (int i = 0; i < N; i++) bin_in[i*BW +: BW] = BW'(ops[i]);
    req = set;
    while (pending != '0) begin
      w = -1;
      for (int s = 1; s <= N; s++) begin
        c = (mptr + s) % N;
        if (w < 0 && pending[c]) w = c;
      end
      if (ops[w] > 999) begin
        lat = 1; exp_err = 1; exp_bcd = 0; exp_st = 0;
      end else if (hang) begin
        lat = TO + 3; exp_err = 1; exp_bcd = 0; exp_st = 1;
      end else begin
        lat = 13; exp_err = 0; exp_bcd = to_bcd(ops[w]); exp_st = 1;
      end
      if (!first) lat = lat + 1;
      wait_ack(lat + 40, k, starts);
      check("ack_index", 32'(ack), 32'(1) << w);
      check("ack_latency", k, lat);
      check("resp_bcd", 32'(resp_bcd), exp_bcd);
      check("resp_err", 32'(resp_err), 32'(exp_err));
      check("start_count", starts, exp_st);
      check("busy_in_resp", 32'(busy), 1);
      req[w] = 1'b0;
      pending[w] = 1'b0;
      mptr = w;
      first = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ops[N];
    int k, starts, w, acks;
    logic [N-1:0] set;
    vectors = 0;
    fails = 0;
    hang = 0;
    req = '0;
    bin_in = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #3;
    check("rst_ack", 32'(ack), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_start", 32'(conv_start), 0);
    check("rst_bcd", 32'(resp_bcd), 0);
    check("rst_err", 32'(resp_err), 0);
    check("rst_bin", 32'(conv_bin), 0);
    @(negedge clk);
    reset_n = 1'b1;
    mptr = N - 1;

    // All four at once, from reset pointer: order 0,1,2,3.
    ops = '{0, 999, 512, 7};
    run_batch(4'b1111, ops);

    // Single request, nominal 13-cycle latency.
    ops = '{345, 0, 0, 0};
    run_batch(4'b0001, ops);

    // Out-of-range operand: immediate error response, no converter start.
    ops = '{0, 0, 1000, 0};
    run_batch(4'b0100, ops);

    // Hung converter hits the watchdog, then normal service resumes.
    hang = 1;
    ops = '{0, 300, 0, 0};
    run_batch(4'b0010, ops);
    hang = 0;
    ops = '{0, 0, 0, 77};
    run_batch(4'b1000, ops);

    // Continuous req[1] and req[3] alternate.
    bin_in = '0;
    bin_in[1*BW +: BW] = 10'd123;
    bin_in[3*BW +: BW] = 10'd654;
    req = 4'b1010;
    for (int g = 0; g < 4; g++) begin
      w = (mptr == 1) ? 3 : 1;
      wait_ack(60, k, starts);
      check("alt_index", 32'(ack), 32'(1) << w);
      check("alt_latency", k, (g == 0) ? 13 : 14);
      check("alt_bcd", 32'(resp_bcd), to_bcd((w == 1) ? 123 : 654));
      mptr = w;
    end
    req = '0;
    @(negedge clk);

    // Requester holds req one cycle past its ack: it must not be served twice.
    bin_in[0 +: BW] = 10'd55;
    req = 4'b0001;
    wait_ack(60, k, starts);
    check("mask_first_ack", 32'(ack), 1);
    mptr = 0;
    @(negedge clk);
    @(negedge clk);
    req = '0;
    acks = 0;
    starts = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ack != '0) acks++;
      if (conv_start) starts++;
    end
    check("mask_no_double_ack", acks, 0);
    check("mask_no_restart", starts, 0);

    // Reset asserted during WAIT aborts silently; pending request then completes.
    bin_in[2*BW +: BW] = 10'd456;
    req = 4'b0100;
    repeat (6) @(negedge clk);
    check("busy_in_wait", 32'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_ack", 32'(ack), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_start", 32'(conv_start), 0);
    check("arst_bin", 32'(conv_bin), 0);
    check("arst_bcd_err", {31'(resp_bcd), resp_err}, 0);
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack != '0) acks++;
    end
    check("arst_no_ack", acks, 0);
    reset_n = 1'b1;
    mptr = N - 1;
    ops = '{0, 0, 456, 0};
    run_batch(4'b0100, ops);

    // Random batches.
    for (int b = 0; b < 10; b++) begin
      set = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++)
        ops[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1000, 1023))
                                             : int'($urandom_range(0, 999));
      run_batch(set, ops);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_conv_arbiter.md
# bcd_conv_arbiter

Round-robin arbiter and sequencer that shares one 10-bit binary-to-BCD converter among N requesters. It sits between the display and readout clients and the converter. It launches each conversion with a one-cycle start pulse, waits for the converter's done tick, and returns the three BCD digits to the granted requester. It also rejects out-of-range operands and guards against a hung converter with a watchdog.

## Interface
- N_REQ, 4, number of requesters (2..8)
- BIN_W, 10, operand width (fixed to the converter width)
- TIMEOUT, 31, max cycles waiting for conv_done_tick before error

- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester request level, held until own ack
- bin_in  in  N_REQ*BIN_W  operands, requester i at [i*BIN_W +: BIN_W]
- ack  out  N_REQ  one-hot, one-cycle completion pulse
- resp_bcd  out  12  {bcd2,bcd1,bcd0}, valid only while ack≠0
- resp_err  out  1  valid with ack: 1 = out-of-range or timeout
- busy  out  1  high in any state other than IDLE
- conv_start  out  1  one-cycle start pulse to the converter
- conv_bin  out  BIN_W  registered operand to the converter
- conv_ready  in  1  converter idle
- conv_done_tick  in  1  converter completion pulse
- conv_bcd2, conv_bcd1, conv_bcd0  in  4 each  converter digits

## Operation
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE
  - If any unmasked req is high and conv_ready is 1, pick the first requester at or after ptr+1 (mod N_REQ).
  - Latch the winner's index into gnt and its operand into conv_bin.
  - If the operand is ≤ 999, go to LAUNCH.
  - If the operand is > 999, go to RESP with resp_err=1 and resp_bcd=0. The converter is not started.
  - If conv_ready is 0, stay in IDLE.
- LAUNCH: conv_start=1 for exactly one cycle; clear the watchdog; go to WAIT.
- WAIT
  - On conv_done_tick, capture the three digits and go to RESP with err=0.
  - If the watchdog reaches TIMEOUT first, go to RESP with err=1 and resp_bcd=0.
  - If both happen in the same cycle, done_tick wins.
- RESP: ack[gnt]=1 for one cycle; set ptr←gnt; go to IDLE.
- Mask: in the first IDLE cycle after RESP, req[gnt] is ignored, so a requester that drops req on seeing ack is not served twice.
- A requester whose req falls before grant is simply not served. A req drop after grant does not abort the conversion; ack is still issued.
- Simultaneous requests: round-robin rotates from the last served requester, so every requester is served within N_REQ grants.
- conv_bin holds its value from LAUNCH until the next grant.

## Timing
- Reset values: state=IDLE, ptr=N_REQ-1 (first grant goes to requester 0), gnt=0, conv_bin=0. ack, resp_bcd, resp_err, busy and conv_start are all 0.
- Reset asserted mid-operation returns all of the above to reset values immediately.
  - The converter shares the same reset, inverted to active-high, so no stale done_tick is accepted.
  - No ack is issued for an aborted conversion.
- Nominal latency, with req first sampled high in IDLE at cycle 0:
  - Cycle 1: LAUNCH.
  - Cycles 2–11: converter shifts.
  - Cycle 12: done_tick.
  - Cycle 13: ack.
  - Total: 13 cycles.
- Out-of-range latency: ack at cycle 1.
- Back-to-back: the next grant decision occurs in cycle 14, so throughput is 1 conversion per 14 cycles.
- All outputs are registered or decoded from registered state only; there are no combinational paths from req or bin_in to outputs.

## Structure
- Shared package: state encoding localparams (IDLE/LAUNCH/WAIT/RESP), BCD_MAX=999, and the 12-bit packed-BCD width.
- One sub-module, rr_pick: combinational round-robin priority encoder (req, mask, ptr → gnt index, any).
- Watchdog counter and FSM in the top. Width is clog2(TIMEOUT+1).

## Test plan
- Single request, bin_in[0]=10'd345 → ack[0] at cycle 13, resp_bcd=12'h345, err=0, exactly one conv_start.
- All four requests high with operands 0, 999, 512, 7 → acks in order 0,1,2,3, each 14 cycles apart. resp_bcd = 12'h000, 12'h999, 12'h512, 12'h007.
- req[2] with bin=10'd1000 → ack[2] at cycle 1, err=1, bcd=0, conv_start never asserted.
- Converter model that never ticks → ack at TIMEOUT+2 cycles after LAUNCH, err=1. The next request is then served normally.
- Continuous req[1] plus req[3] → grants alternate 1,3,1,3. The mask prevents a double ack for 1 in the cycle after its RESP.
- reset_n pulsed low during WAIT → all outputs 0 asynchronously and no ack. After release, a pending request completes in 13 cycles.
